// File: rtl/core_pkg.sv
// Shared decode-stage types: immediate format codes and instruction payload width.
package core_pkg;

    typedef enum logic [2:0] {
        ITYPE  = 3'd0,
        STYPE  = 3'd1,
        BTYPE  = 3'd2,
        UTYPE  = 3'd3,
        JTYPE  = 3'd4,
        ZTYPE  = 3'd5,
        SHTYPE = 3'd6
    } imm_type_t;

    localparam int IMM_IN_W = 25;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate format mux and sign/zero extension to XLEN.
// immed holds instr[31:7], so immed[k] is instruction bit k+7.
module imm_extend
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [IMM_IN_W-1:0] immed,
    input  logic [2:0]          imm_ctrl,
    output logic [XLEN-1:0]     imm_ext,
    output logic                imm_err
);

    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic [5:0]  sh_amt;

    always_comb begin
        i_imm  = 32'($signed(immed[24:13]));
        s_imm  = 32'($signed({immed[24:18], immed[4:0]}));
        b_imm  = 32'($signed({immed[24], immed[0], immed[23:18], immed[4:1], 1'b0}));
        u_imm  = {immed[24:5], 12'b0};
        j_imm  = 32'($signed({immed[24], immed[12:5], immed[13], immed[23:14], 1'b0}));
        // RV64 shift amounts carry one extra bit
        sh_amt = (XLEN == 64) ? immed[18:13] : {1'b0, immed[17:13]};
    end

    always_comb begin
        imm_ext = '0;
        imm_err = 1'b0;
        case (imm_ctrl)
            ITYPE:   imm_ext = XLEN'($signed(i_imm));
            STYPE:   imm_ext = XLEN'($signed(s_imm));
            BTYPE:   imm_ext = XLEN'($signed(b_imm));
            UTYPE:   imm_ext = XLEN'($signed(u_imm));
            JTYPE:   imm_ext = XLEN'($signed(j_imm));
            ZTYPE:   imm_ext = XLEN'(immed[12:8]);
            SHTYPE:  imm_ext = XLEN'(sh_amt);
            default: imm_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry (output + skid) valid/ready stage.
// in_ready comes straight from the skid flag, so it never depends on out_ready.
module imm_gen_pipe
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_IN_W-1:0] immed,
    input  logic [2:0]          imm_ctrl,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     imm_ext,
    output logic                imm_err,
    output logic [TAG_W-1:0]    out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  new_imm;
    logic             new_err;
    logic             skid_full;
    logic [XLEN-1:0]  skid_imm;
    logic             skid_err;
    logic [TAG_W-1:0] skid_tag;

    imm_extend #(.XLEN(XLEN)) u_extend (
        .immed    (immed),
        .imm_ctrl (imm_ctrl),
        .imm_ext  (new_imm),
        .imm_err  (new_err)
    );

    assign in_ready = !skid_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            imm_ext   <= '0;
            imm_err   <= 1'b0;
            out_tag   <= '0;
            skid_full <= 1'b0;
            skid_imm  <= '0;
            skid_err  <= 1'b0;
            skid_tag  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Output slot is free this cycle; the skid beat is older, so it goes first.
            if (skid_full) begin
                imm_ext   <= skid_imm;
                imm_err   <= skid_err;
                out_tag   <= skid_tag;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (in_valid) begin
                imm_ext   <= new_imm;
                imm_err   <= new_err;
                out_tag   <= in_tag;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid && !skid_full) begin
            skid_imm  <= new_imm;
            skid_err  <= new_err;
            skid_tag  <= in_tag;
            skid_full <= 1'b1;
        end
    end

endmodule
